// File: rtl/arm_run_controller.sv
// rtl/arm_run_controller.sv - run sequencer for the ARM pipeline core: reset hold, divided clock-enable, stop detection
//
// Purpose:
//   Holds the core in reset for RST_CYCLES after a start is accepted, then runs it.
//   While running it produces a divided clock-enable and counts RUN cycles. It also
//   watches the PC for a spin loop. The run ends on a halt request, a PC stall or a
//   cycle timeout. The core is then frozen and the cause is reported.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   start        begin a run; accepted only in IDLE or DONE
//   fwd_mode_in  forwarding mode, latched on an accepted start
//   halt_req     external or core halt request
//   pc           core program counter
//   pc_valid     pc is meaningful this cycle
//   core_rst     reset to the core (high in IDLE and HOLD)
//   clk_en       divided clock-enable, high only in RUN
//   forward_enb  forwarding enable, constant for a whole run
//   done         run finished
//   done_reason  0 none, 1 halt, 2 stall, 3 timeout
//   cycle_count  RUN cycles elapsed, saturating

module arm_run_controller #(
    parameter int DIV_RATIO   = 2,
    parameter int RST_CYCLES  = 1,
    parameter int MAX_CYCLES  = 1000,
    parameter int STALL_LIMIT = 16,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fwd_mode_in,
    input  logic             halt_req,
    input  logic [PC_W-1:0]  pc,
    input  logic             pc_valid,
    output logic             core_rst,
    output logic             clk_en,
    output logic             forward_enb,
    output logic             done,
    output logic [1:0]       done_reason,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DIV_W   = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
    localparam int RST_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DIV_W-1:0]   div_cnt;
    logic [RST_W-1:0]   rst_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [PC_W-1:0]    last_pc;
    logic               last_pc_vld;
    logic               fwd_q;
    logic [1:0]         reason_q;
    logic [CNT_W-1:0]   cnt_q;

    logic       tick;
    logic       hold_last;
    logic       stall_hit;
    logic       timeout_hit;
    logic [1:0] exit_reason;
    logic       accept_start;

    always_comb begin
        tick         = (state == S_RUN) && (div_cnt == DIV_W'(DIV_RATIO - 1));
        hold_last    = (rst_cnt == RST_W'(RST_CYCLES - 1));
        stall_hit    = (STALL_LIMIT != 0) && (stall_cnt >= STALL_W'(STALL_LIMIT));
        timeout_hit  = (MAX_CYCLES != 0) && (cnt_q == CNT_W'(MAX_CYCLES - 1));
        accept_start = start && ((state == S_IDLE) || (state == S_DONE));

        // Priority: halt over stall over timeout.
        exit_reason = 2'd0;
        if (halt_req) begin
            exit_reason = 2'd1;
        end else if (stall_hit) begin
            exit_reason = 2'd2;
        end else if (timeout_hit) begin
            exit_reason = 2'd3;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_HOLD;
            S_HOLD: if (hold_last) state_nxt = S_RUN;
            S_RUN:  if (exit_reason != 2'd0) state_nxt = S_DONE;
            S_DONE: if (start) state_nxt = S_HOLD;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            rst_cnt     <= '0;
            stall_cnt   <= '0;
            last_pc     <= '0;
            last_pc_vld <= 1'b0;
            fwd_q       <= 1'b0;
            reason_q    <= 2'd0;
            cnt_q       <= '0;
        end else begin
            state <= state_nxt;

            if (accept_start) begin
                fwd_q       <= fwd_mode_in;
                rst_cnt     <= '0;
                div_cnt     <= '0;
                stall_cnt   <= '0;
                last_pc_vld <= 1'b0;
                reason_q    <= 2'd0;
                cnt_q       <= '0;
            end

            if (state == S_HOLD) begin
                rst_cnt <= rst_cnt + RST_W'(1);
            end

            if (state == S_RUN) begin
                if (div_cnt == DIV_W'(DIV_RATIO - 1)) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end

                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end

                // The PC is only looked at on slow-domain ticks, where the core actually advances.
                if (tick && pc_valid) begin
                    if (last_pc_vld && (pc == last_pc)) begin
                        if (stall_cnt != '1) begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                        end
                    end else begin
                        stall_cnt   <= '0;
                        last_pc     <= pc;
                        last_pc_vld <= 1'b1;
                    end
                end

                if (exit_reason != 2'd0) begin
                    reason_q <= exit_reason;
                end
            end
        end
    end

    // Outputs are decoded from registered state only.
    assign core_rst    = (state == S_IDLE) || (state == S_HOLD);
    assign clk_en      = tick;
    assign forward_enb = fwd_q;
    assign done        = (state == S_DONE);
    assign done_reason = reason_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_arm_run_controller.sv
// tb/tb_arm_run_controller.sv - self-checking bench for arm_run_controller with DIV_RATIO 2 and 1 instances

module tb_arm_run_controller;

    localparam int RSTC   = 3;
    localparam int MAXC   = 20;
    localparam int STALLL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        fwd_mode_in;
    logic        halt_req;
    logic [31:0] pc;
    logic        pc_valid;

    logic [1:0]  core_rst_o;
    logic [1:0]  clk_en_o;
    logic [1:0]  fwd_o;
    logic [1:0]  done_o;
    logic [1:0]  reason_o [2];
    logic [31:0] cnt_o    [2];

    int errors = 0;
    int checks = 0;

    arm_run_controller #(
        .DIV_RATIO(2), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
        .STALL_LIMIT(STALLL), .PC_W(32), .CNT_W(32)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .fwd_mode_in(fwd_mode_in),
        .halt_req(halt_req), .pc(pc), .pc_valid(pc_valid),
        .core_rst(core_rst_o[0]), .clk_en(clk_en_o[0]), .forward_enb(fwd_o[0]),
        .done(done_o[0]), .done_reason(reason_o[0]), .cycle_count(cnt_o[0])
    );

    arm_run_controller #(
        .DIV_RATIO(1), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
        .STALL_LIMIT(STALLL), .PC_W(32), .CNT_W(32)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .fwd_mode_in(fwd_mode_in),
        .halt_req(halt_req), .pc(pc), .pc_valid(pc_valid),
        .core_rst(core_rst_o[1]), .clk_en(clk_en_o[1]), .forward_enb(fwd_o[1]),
        .done(done_o[1]), .done_reason(reason_o[1]), .cycle_count(cnt_o[1])
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 hold, 2 run, 3 done; k = RUN cycles completed.
    int          divr [2] = '{2, 1};
    int          ph [2];
    int          hold_n [2];
    int          k [2];
    int          fwd [2];
    int          reason [2];
    int          have_last [2];
    int          rep [2];
    logic [31:0] lastp [2];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int why;
        bit en;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i] = 0; fwd[i] = 0; reason[i] = 0; k[i] = 0;
                have_last[i] = 0; rep[i] = 0; hold_n[i] = 0;
            end else begin
                case (ph[i])
                    0: if (start) begin
                        fwd[i] = int'(fwd_mode_in); ph[i] = 1; hold_n[i] = 0;
                        k[i] = 0; have_last[i] = 0; rep[i] = 0; reason[i] = 0;
                    end
                    1: begin
                        hold_n[i]++;
                        if (hold_n[i] == RSTC) ph[i] = 2;
                    end
                    2: begin
                        en  = ((k[i] + 1) % divr[i]) == 0;
                        why = halt_req ? 1 : (rep[i] >= STALLL) ? 2 : (k[i] == MAXC - 1) ? 3 : 0;
                        k[i]++;
                        if (en && pc_valid) begin
                            if (have_last[i] != 0 && pc == lastp[i]) rep[i]++;
                            else begin rep[i] = 0; lastp[i] = pc; have_last[i] = 1; end
                        end
                        if (why != 0) begin ph[i] = 3; reason[i] = why; end
                    end
                    default: if (start) begin
                        reason[i] = 0; k[i] = 0; have_last[i] = 0; rep[i] = 0;
                        fwd[i] = int'(fwd_mode_in); ph[i] = 1; hold_n[i] = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("core_rst[%0d]", i), 64'(core_rst_o[i]), 64'(ph[i] < 2));
            chk($sformatf("clk_en[%0d]", i), 64'(clk_en_o[i]),
                64'(ph[i] == 2 && ((k[i] + 1) % divr[i]) == 0));
            chk($sformatf("forward_enb[%0d]", i), 64'(fwd_o[i]), 64'(fwd[i]));
            chk($sformatf("done[%0d]", i), 64'(done_o[i]), 64'(ph[i] == 3));
            chk($sformatf("done_reason[%0d]", i), 64'(reason_o[i]), 64'(reason[i]));
            chk($sformatf("cycle_count[%0d]", i), 64'(cnt_o[i]), 64'(k[i]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    function automatic logic rand_start();
        return (ph[0] != 3 && ph[1] != 3 && ph[0] != 0) ? logic'($urandom_range(0, 3) == 0) : 1'b0;
    endfunction

    initial begin
        int rc;
        rst = 1'b1; start = 1'b0; fwd_mode_in = 1'b0; halt_req = 1'b0;
        pc = 32'h0; pc_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; hold_n[i] = 0; k[i] = 0; fwd[i] = 0; reason[i] = 0;
            have_last[i] = 0; rep[i] = 0; lastp[i] = 32'h0;
        end
        cyc(); cyc();
        chk("reset_core_rst", 64'(core_rst_o), 64'(2'b11));
        chk("reset_done", 64'(done_o), 64'(2'b00));
        rst = 1'b0;

        // fwd_mode_in wiggles without a start must not reach forward_enb.
        repeat (3) begin fwd_mode_in = 1'($urandom); cyc(); end

        // Timeout run: PC advancing by 4, stray start pulses while running.
        start = 1'b1; fwd_mode_in = 1'b1; cyc();
        start = 1'b0; fwd_mode_in = 1'b0;
        for (int n = 0; n < 40 && done_o != 2'b11; n++) begin
            pc = pc + 32'd4; pc_valid = 1'b1; start = rand_start();
            fwd_mode_in = 1'($urandom);
            cyc();
        end
        start = 1'b0;
        chk("to_done", 64'(done_o), 64'(2'b11));
        chk("to_reason_a", 64'(reason_o[0]), 64'd3);
        chk("to_count_a", 64'(cnt_o[0]), 64'd20);
        chk("to_fwd_a", 64'(fwd_o[0]), 64'd1);
        chk("to_clk_en", 64'(clk_en_o), 64'd0);
        chk("to_core_rst", 64'(core_rst_o), 64'd0);

        // Stall run: PC sticks at 0x40 from the third slow sample of dut_a.
        start = 1'b1; fwd_mode_in = 1'b0; cyc();
        start = 1'b0;
        chk("restart_count", 64'(cnt_o[0]), 64'd0);
        chk("restart_done", 64'(done_o), 64'd0);
        for (int n = 0; n < 40 && done_o != 2'b11; n++) begin
            rc = (ph[0] == 2) ? k[0] + 1 : 0;
            pc = (rc <= 2) ? 32'h0 : (rc <= 4) ? 32'h4 : 32'h40;
            pc_valid = 1'b1;
            cyc();
        end
        chk("stall_reason_a", 64'(reason_o[0]), 64'd2);
        chk("stall_reason_b", 64'(reason_o[1]), 64'd2);
        chk("stall_fwd_a", 64'(fwd_o[0]), 64'd0);

        // PC repeats at most 3 times per value on dut_a samples, so it must time out.
        start = 1'b1; fwd_mode_in = 1'b1; cyc();
        start = 1'b0;
        for (int n = 0; n < 40 && done_o != 2'b11; n++) begin
            rc = (ph[0] == 2) ? k[0] + 1 : 0;
            pc = 32'h100 + 32'(((rc / 2) / 4) * 4);
            pc_valid = 1'b1;
            cyc();
        end
        chk("nostall_reason_a", 64'(reason_o[0]), 64'd3);

        // Priority: on dut_b halt, stall and timeout all fire in RUN cycle 20.
        start = 1'b1; fwd_mode_in = 1'b0; cyc();
        start = 1'b0;
        for (int n = 0; n < 40 && done_o != 2'b11; n++) begin
            rc = (ph[1] == 2) ? k[1] + 1 : 0;
            pc = (rc <= 14) ? 32'(rc * 4) : 32'h40;
            pc_valid = 1'b1;
            halt_req = (ph[1] == 2 && k[1] == MAXC - 1);
            if (halt_req) begin
                chk("prio_stall_armed", 64'(rep[1] >= STALLL), 64'd1);
            end
            cyc();
        end
        halt_req = 1'b0;
        chk("prio_reason_b", 64'(reason_o[1]), 64'd1);
        chk("prio_reason_a", 64'(reason_o[0]), 64'd1);

        // Random run: two-value PC, random pc_valid, occasional halt.
        start = 1'b1; fwd_mode_in = 1'($urandom); cyc();
        start = 1'b0;
        for (int n = 0; n < 40 && done_o != 2'b11; n++) begin
            pc = ($urandom_range(0, 1) == 0) ? 32'h40 : 32'h44;
            pc_valid = 1'($urandom);
            halt_req = ($urandom_range(0, 15) == 0);
            start = rand_start();
            cyc();
        end
        halt_req = 1'b0; start = 1'b0;
        chk("rand_done", 64'(done_o), 64'(2'b11));

        // Reset in the middle of RUN.
        start = 1'b1; fwd_mode_in = 1'b1; cyc();
        start = 1'b0;
        for (int n = 0; n < 8; n++) begin
            pc = 32'($urandom); pc_valid = 1'b1; cyc();
        end
        rst = 1'b1; cyc();
        rst = 1'b0;
        chk("midrst_core_rst", 64'(core_rst_o), 64'(2'b11));
        chk("midrst_fwd", 64'(fwd_o), 64'd0);
        chk("midrst_count", 64'(cnt_o[0]), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        start = 1'b1; fwd_mode_in = 1'b0; cyc();
        start = 1'b0;
        repeat (6) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm_run_controller.md
Name: arm_run_controller

Overview:
- Parametrised run controller for the ARM pipeline core.
- Sequences core reset, generates a divided clock-enable for slow domains (e.g. SRAM side), and latches the forwarding-enable mode per run.
- Ends a run on halt request, PC stall (program spin loop) or cycle timeout, and reports the cause.
- Sits between the top level / bench and ARM_PROCESSOR; replaces ad-hoc reset, clock-divide and stop logic.

Parameters:
- DIV_RATIO, 2, clk_en period in clk cycles during RUN; 1 means clk_en is always high in RUN.
- RST_CYCLES, 1, number of cycles core_rst is held in HOLD; minimum 1.
- MAX_CYCLES, 1000, RUN-cycle timeout; 0 disables timeout.
- STALL_LIMIT, 16, consecutive identical sampled PCs that signal a stall; 0 disables stall detection.
- PC_W, 32, PC width.
- CNT_W, 32, cycle counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a run (single-cycle pulse or level)
- fwd_mode_in  in  1  forwarding mode, sampled on an accepted start
- halt_req  in  1  external or core halt request
- pc  in  PC_W  core program counter
- pc_valid  in  1  pc is meaningful this cycle
- core_rst  out  1  reset to ARM_PROCESSOR
- clk_en  out  1  divided clock-enable
- forward_enb  out  1  forwarding enable to core
- done  out  1  run finished
- done_reason  out  2  0 none, 1 halt, 2 stall, 3 timeout
- cycle_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset (synchronous, rst=1 at posedge clk): state=IDLE, core_rst=1, clk_en=0, forward_enb=0, done=0, done_reason=0, cycle_count=0. div_cnt, stall_cnt and last_pc are cleared. Reset overrides every state, including mid-RUN.
- IDLE: core_rst=1.
  - start=1: forward_enb<=fwd_mode_in; rst_cnt<=0; go to HOLD.
- HOLD: core_rst=1, clk_en=0.
  - rst_cnt increments each cycle.
  - After exactly RST_CYCLES cycles in HOLD, go to RUN.
  - start is ignored.
- RUN: core_rst=0.
  - div_cnt counts 0..DIV_RATIO-1 and wraps.
  - clk_en=1 in cycles where div_cnt==DIV_RATIO-1. With DIV_RATIO=2, the first clk_en is in the 2nd RUN cycle; clk_en is then high every 2nd cycle.
  - cycle_count increments every RUN cycle and saturates at all-ones.
  - Stall detection runs only on cycles with clk_en=1 and pc_valid=1:
    - pc==last_pc: stall_cnt++.
    - Otherwise: stall_cnt<=0 and last_pc<=pc.
    - last_pc starts invalid, so the first sample never counts as a repeat.
  - Exit conditions are evaluated each cycle, in priority order when simultaneous:
    - halt_req=1 gives reason 1.
    - stall_cnt reaching STALL_LIMIT gives reason 2.
    - cycle_count==MAX_CYCLES-1 gives reason 3.
  - Any exit moves to DONE on the next edge.
  - start is ignored.
- DONE: done=1, done_reason held, clk_en=0, core_rst=0 (core state frozen for inspection), cycle_count frozen.
  - start=1: clear done, done_reason, cycle_count, div_cnt, stall_cnt and last_pc; relatch forward_enb; go to HOLD.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- forward_enb is constant for a whole run. Changing fwd_mode_in outside an accepted start has no effect.

Test Plan:
- Reset, then start with fwd_mode_in=1, RST_CYCLES=3 -> core_rst high for exactly 3 cycles after start is accepted; forward_enb=1; RUN entered on cycle 4.
- DIV_RATIO=2, RUN for 10 cycles -> clk_en high on RUN cycles 2,4,6,8,10; DIV_RATIO=1 -> clk_en high on every RUN cycle; clk_en=0 in IDLE/HOLD/DONE.
- MAX_CYCLES=20, no halt, PC incrementing by 4 -> done=1, done_reason=3, cycle_count=20, core_rst=0, clk_en=0.
- STALL_LIMIT=4, PC stuck at 0x40 from the 3rd sample -> done_reason=2 after 4 repeated clk_en samples; a PC change before the limit resets stall_cnt and no stall is reported.
- Priority: halt_req asserted in the same cycle that stall and timeout both trigger -> done_reason=1.
- Restart and reset: start in DONE with fwd_mode_in=0 -> done clears, cycle_count=0, forward_enb=0, HOLD re-entered. rst asserted mid-RUN -> next cycle IDLE, all outputs at reset values; start pulses during HOLD/RUN are ignored.
